// File: rtl/trap_sequencer_if.sv
// Handshake between the interrupt/fault priority encoder, the CPU PC logic and
// the trap sequencer. The slave side is the sequencer itself.
interface trap_sequencer_if;
  logic [7:0]  trapnr;
  logic        irq;
  logic        fault;
  logic        irq_en;
  logic        insn_boundary;
  logic [15:0] cur_pc;
  logic        reti;
  logic        deassert;
  logic        pc_load;
  logic [15:0] pc_out;
  logic        trap_active;
  logic [15:0] epc;
  logic [2:0]  cause;
  logic        halted;

  modport master (
    output trapnr, irq, fault, irq_en, insn_boundary, cur_pc, reti,
    input  deassert, pc_load, pc_out, trap_active, epc, cause, halted
  );

  modport slave (
    input  trapnr, irq, fault, irq_en, insn_boundary, cur_pc, reti,
    output deassert, pc_load, pc_out, trap_active, epc, cause, halted
  );
endinterface

// File: rtl/trap_sequencer.sv
// Sequences trap entry/exit: saves EPC, loads the handler vector, retires the
// serviced encoder bit, restores PC on reti and halts on a double fault.
module trap_sequencer #(
  parameter logic [15:0] VEC_BASE = 16'h0008
) (
  input  logic              clk,
  input  logic              reset,
  trap_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_HANDLER,
    ST_RETURN,
    ST_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] epc_q, epc_d;
  logic [2:0]  cause_q, cause_d;
  logic [2:0]  idx;
  logic        take_trap;

  // Lowest set bit wins, matching the order in which the encoder retires bits.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.trapnr[i]) idx = 3'(i);
    end
  end

  // Faults are precise and ignore the boundary; interrupts wait for one.
  assign take_trap = bus.fault | (bus.irq & bus.irq_en & bus.insn_boundary);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      epc_q   <= 16'h0000;
      cause_q <= 3'd0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take_trap) begin
          epc_d   = bus.cur_pc;
          cause_d = idx;
          state_d = ST_ENTER;
        end
      end
      ST_ENTER:   state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (bus.fault)     state_d = ST_HALT;
        else if (bus.reti) state_d = ST_RETURN;
      end
      ST_RETURN:  state_d = ST_IDLE;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure decodes of state and the saved registers.
  always_comb begin
    bus.deassert    = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_out      = 16'h0000;
    bus.trap_active = 1'b1;
    bus.halted      = 1'b0;
    unique case (state_q)
      ST_IDLE:    bus.trap_active = 1'b0;
      ST_ENTER: begin
        bus.deassert = 1'b1;
        bus.pc_load  = 1'b1;
        bus.pc_out   = VEC_BASE + {11'd0, cause_q, 2'b00};
      end
      ST_HANDLER: ;
      ST_RETURN: begin
        bus.pc_load = 1'b1;
        bus.pc_out  = epc_q;
      end
      ST_HALT:    bus.halted = 1'b1;
      default:    bus.trap_active = 1'b0;
    endcase
  end

  assign bus.epc   = epc_q;
  assign bus.cause = cause_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer; the bench plays the encoder and CPU and
// checks outputs one time unit after each rising edge.
module tb_trap_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  trap_sequencer_if bus ();

  trap_sequencer #(.VEC_BASE(16'h0008)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encoder model: summaries follow the bitmap.
  task automatic set_pend(input logic [7:0] v);
    bus.trapnr = v;
    bus.irq    = |v[5:2];
    bus.fault  = |v[1:0];
  endtask

  initial begin
    reset = 1'b1;
    set_pend(8'h00);
    bus.irq_en        = 1'b0;
    bus.insn_boundary = 1'b0;
    bus.cur_pc        = 16'h0000;
    bus.reti          = 1'b0;
    tick();
    tick();
    check("rst_deassert", bus.deassert, 0);
    check("rst_pc_load", bus.pc_load, 0);
    check("rst_pc_out", bus.pc_out, 0);
    check("rst_active", bus.trap_active, 0);
    check("rst_epc", bus.epc, 0);
    check("rst_cause", bus.cause, 0);
    check("rst_halted", bus.halted, 0);
    reset = 1'b0;

    // Interrupt gated by irq_en, then by insn_boundary.
    set_pend(8'h04);
    bus.irq_en = 1'b0; bus.insn_boundary = 1'b1; bus.cur_pc = 16'h0120;
    tick();
    check("gate_en_load", bus.pc_load, 0);
    check("gate_en_deassert", bus.deassert, 0);
    check("gate_en_active", bus.trap_active, 0);
    bus.irq_en = 1'b1; bus.insn_boundary = 1'b0;
    tick();
    check("gate_ib_load", bus.pc_load, 0);
    check("gate_ib_active", bus.trap_active, 0);

    // Interrupt entry, cause 2.
    bus.insn_boundary = 1'b1;
    tick();
    check("irq2_load", bus.pc_load, 1);
    check("irq2_vec", bus.pc_out, 16'h0010);
    check("irq2_deassert", bus.deassert, 1);
    check("irq2_cause", bus.cause, 2);
    check("irq2_epc", bus.epc, 16'h0120);
    check("irq2_active", bus.trap_active, 1);
    set_pend(8'h00);
    bus.cur_pc = 16'h0124;
    tick();
    check("hnd_load", bus.pc_load, 0);
    check("hnd_deassert", bus.deassert, 0);
    check("hnd_active", bus.trap_active, 1);
    check("hnd_epc_hold", bus.epc, 16'h0120);

    // reti with irq 5 pending: no nesting, re-entry only after IDLE.
    bus.reti = 1'b1;
    set_pend(8'h20);
    tick();
    bus.reti = 1'b0;
    check("ret_load", bus.pc_load, 1);
    check("ret_pc", bus.pc_out, 16'h0120);
    check("ret_active", bus.trap_active, 1);
    check("ret_deassert", bus.deassert, 0);
    bus.cur_pc = 16'h0300;
    tick();
    check("ret_idle_active", bus.trap_active, 0);
    check("ret_idle_load", bus.pc_load, 0);
    tick();
    check("irq5_load", bus.pc_load, 1);
    check("irq5_vec", bus.pc_out, 16'h001C);
    check("irq5_cause", bus.cause, 5);
    check("irq5_epc", bus.epc, 16'h0300);
    set_pend(8'h00);
    tick();
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    check("ret5_pc", bus.pc_out, 16'h0300);
    tick();
    check("ret5_idle", bus.trap_active, 0);

    // reti in IDLE ignored; bits 7:6 alone take no trap.
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    check("idle_reti_load", bus.pc_load, 0);
    set_pend(8'hC0);
    tick();
    tick();
    check("hi_bits_load", bus.pc_load, 0);
    check("hi_bits_active", bus.trap_active, 0);

    // Fault and irq together: one trap, cause 0.
    set_pend(8'h05);
    bus.cur_pc = 16'h0500;
    tick();
    check("both_vec", bus.pc_out, 16'h0008);
    check("both_cause", bus.cause, 0);
    set_pend(8'h04);
    tick();
    check("both_hnd_deassert", bus.deassert, 0);
    set_pend(8'h00);
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    tick();
    check("both_back_idle", bus.trap_active, 0);

    // Fault entry off an instruction boundary.
    set_pend(8'h02);
    bus.insn_boundary = 1'b0;
    bus.cur_pc = 16'h0200;
    tick();
    check("flt_vec", bus.pc_out, 16'h000C);
    check("flt_cause", bus.cause, 1);
    check("flt_epc", bus.epc, 16'h0200);
    check("flt_deassert", bus.deassert, 1);
    set_pend(8'h00);
    tick();

    // Double fault with simultaneous reti: fault wins, core halts.
    set_pend(8'h01);
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    check("dbl_halted", bus.halted, 1);
    check("dbl_active", bus.trap_active, 1);
    check("dbl_load", bus.pc_load, 0);
    set_pend(8'h04);
    bus.insn_boundary = 1'b1;
    bus.reti = 1'b1;
    tick();
    tick();
    bus.reti = 1'b0;
    check("halt_load", bus.pc_load, 0);
    check("halt_deassert", bus.deassert, 0);
    check("halt_sticky", bus.halted, 1);
    reset = 1'b1;
    set_pend(8'h00);
    tick();
    reset = 1'b0;
    check("halt_rst_halted", bus.halted, 0);
    check("halt_rst_active", bus.trap_active, 0);
    check("halt_rst_epc", bus.epc, 0);

    // Two pending interrupts serviced in priority order.
    set_pend(8'h0C);
    bus.cur_pc = 16'h0400;
    tick();
    check("two_a_cause", bus.cause, 2);
    check("two_a_deassert", bus.deassert, 1);
    set_pend(8'h08);
    tick();
    check("two_a_hnd_deassert", bus.deassert, 0);
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    check("two_a_ret_deassert", bus.deassert, 0);
    tick();
    check("two_a_idle_deassert", bus.deassert, 0);
    tick();
    check("two_b_cause", bus.cause, 3);
    check("two_b_vec", bus.pc_out, 16'h0014);
    check("two_b_deassert", bus.deassert, 1);
    set_pend(8'h00);
    tick();
    check("two_b_hnd_deassert", bus.deassert, 0);

    // Reset during ENTER drops the in-flight pulses.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_pend(8'h04);
    tick();
    check("pre_rst_deassert", bus.deassert, 1);
    reset = 1'b1;
    set_pend(8'h00);
    tick();
    reset = 1'b0;
    check("mid_rst_deassert", bus.deassert, 0);
    check("mid_rst_load", bus.pc_load, 0);
    check("mid_rst_cause", bus.cause, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
